// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector.
// One serial bit is consumed per enabled cycle. The pattern, its length and
// the overlap mode are loaded through a one-cycle strobe. Every detection
// gives a one-cycle registered pulse and bumps a saturating match counter.

module seq_detector_param #(
   parameter int  MAX_LEN = 8,
   parameter int  CNT_W   = 8,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               bit_in,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               clr_cnt,
   output logic               match,
   output logic               armed,
   output logic [CNT_W-1:0]   match_count,
   output logic               cnt_sat
);

   localparam logic [LEN_W-1:0]   LEN_ONE = LEN_W'(1);
   localparam logic [LEN_W-1:0]   LEN_DEF = LEN_W'(4);
   localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);
   localparam logic [MAX_LEN-1:0] PAT_DEF = MAX_LEN'(4'b1011);
   localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

   // Bit mask covering the low 'len' bits of a pattern-wide word.
   function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
      logic [MAX_LEN-1:0] m;
      m = {MAX_LEN{1'b0}};
      for (int i = 0; i < MAX_LEN; i++) begin
         m[i] = (LEN_W'(i) < len);
      end
      return m;
   endfunction

   // Force a requested length into the supported range 1..MAX_LEN.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      logic [LEN_W-1:0] r;
      if (len == {LEN_W{1'b0}}) begin
         r = LEN_ONE;
      end else if (len > LEN_MAX) begin
         r = LEN_MAX;
      end else begin
         r = len;
      end
      return r;
   endfunction

   // Compare the active low 'len' bits of the window against the pattern.
   function automatic logic window_hit(input logic [MAX_LEN-1:0] window,
                                       input logic [MAX_LEN-1:0] pat,
                                       input logic [LEN_W-1:0]   len);
      return (((window ^ pat) & len_mask(len)) == {MAX_LEN{1'b0}});
   endfunction

   // Configuration state
   logic [MAX_LEN-1:0] pat_r;
   logic [LEN_W-1:0]   len_r;
   logic               ovl_r;
   // History: only the newest MAX_LEN-1 bits can ever sit in a window next
   // to the incoming bit, so the oldest position is not stored.
   logic [MAX_LEN-2:0] hist_r;
   logic [LEN_W-1:0]   fill_r;
   // Output state
   logic               match_r;
   logic               armed_r;
   logic [CNT_W-1:0]   count_r;
   logic               sat_r;

   // Next-state values
   logic [MAX_LEN-1:0] pat_nxt_s;
   logic [LEN_W-1:0]   len_nxt_s;
   logic               ovl_nxt_s;
   logic [MAX_LEN-2:0] hist_nxt_s;
   logic [LEN_W-1:0]   fill_nxt_s;
   logic               armed_nxt_s;
   logic [CNT_W-1:0]   cnt_base_s;
   logic [CNT_W-1:0]   count_nxt_s;
   logic [MAX_LEN-1:0] window_s;
   logic               hit_s;

   // Detection: the incoming bit completes the window when enough valid history exists
   always_comb begin
      window_s = {hist_r, bit_in};
      if (ena && !cfg_load && (fill_r >= (len_r - LEN_ONE))) begin
         hit_s = window_hit(window_s, pat_r, len_r);
      end else begin
         hit_s = 1'b0;
      end
   end

   // Next configuration, history and fill level; a load wins over a sample
   always_comb begin
      pat_nxt_s  = pat_r;
      len_nxt_s  = len_r;
      ovl_nxt_s  = ovl_r;
      hist_nxt_s = hist_r;
      fill_nxt_s = fill_r;
      if (cfg_load) begin
         pat_nxt_s  = cfg_pattern;
         len_nxt_s  = clamp_len(cfg_len);
         ovl_nxt_s  = cfg_overlap;
         fill_nxt_s = {LEN_W{1'b0}};
      end else if (ena) begin
         hist_nxt_s = window_s[MAX_LEN-2:0];
         if (hit_s && !ovl_r) begin
            // Non-overlapping: the next match must be built from fresh bits
            fill_nxt_s = {LEN_W{1'b0}};
         end else if (fill_r != LEN_MAX) begin
            fill_nxt_s = fill_r + LEN_ONE;
         end else begin
            fill_nxt_s = fill_r;
         end
      end else begin
         hist_nxt_s = hist_r;
         fill_nxt_s = fill_r;
      end
      armed_nxt_s = (fill_nxt_s >= (len_nxt_s - LEN_ONE));
   end

   // Counter: clear is applied first, then a hit in the same cycle counts
   always_comb begin
      if (clr_cnt) begin
         cnt_base_s = CNT_ZERO;
      end else begin
         cnt_base_s = count_r;
      end
      if (hit_s && (cnt_base_s != CNT_MAX)) begin
         count_nxt_s = cnt_base_s + CNT_ONE;
      end else begin
         count_nxt_s = cnt_base_s;
      end
   end

   // Configuration registers: default 1011/len 4/overlap on reset, replaced on load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_r <= PAT_DEF;
         len_r <= LEN_DEF;
         ovl_r <= 1'b1;
      end else begin
         pat_r <= pat_nxt_s;
         len_r <= len_nxt_s;
         ovl_r <= ovl_nxt_s;
      end
   end

   // History shift register and valid-bit fill level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_r <= {(MAX_LEN-1){1'b0}};
         fill_r <= {LEN_W{1'b0}};
      end else begin
         hist_r <= hist_nxt_s;
         fill_r <= fill_nxt_s;
      end
   end

   // Registered outputs: match pulse, armed flag, counter and saturation flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_r <= 1'b0;
         armed_r <= 1'b0;
         count_r <= CNT_ZERO;
         sat_r   <= 1'b0;
      end else begin
         match_r <= hit_s;
         armed_r <= armed_nxt_s;
         count_r <= count_nxt_s;
         sat_r   <= (count_nxt_s == CNT_MAX);
      end
   end

   assign match       = match_r;
   assign armed       = armed_r;
   assign match_count = count_r;
   assign cnt_sat     = sat_r;

   seq_detector_param_chk #(
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W),
      .LEN_W   (LEN_W)
   ) u_chk (
      .clk         (clk),
      .rst_n       (rst_n),
      .fill        (fill_r),
      .len         (len_r),
      .match_count (count_r),
      .cnt_sat     (sat_r)
   );

endmodule

// seq_detector_param_chk: invariants of the detector's internal state.
module seq_detector_param_chk #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   parameter int LEN_W   = 4
) (
   input logic             clk,
   input logic             rst_n,
   input logic [LEN_W-1:0] fill,
   input logic [LEN_W-1:0] len,
   input logic [CNT_W-1:0] match_count,
   input logic             cnt_sat
);

   a_fill_bound : assert property (@(posedge clk) disable iff (!rst_n)
      fill <= LEN_W'(MAX_LEN));

   a_len_range : assert property (@(posedge clk) disable iff (!rst_n)
      (len >= LEN_W'(1)) && (len <= LEN_W'(MAX_LEN)));

   a_sat_flag : assert property (@(posedge clk) disable iff (!rst_n)
      cnt_sat == (&match_count));

endmodule
